dcache_rsp_unit: RTL

Data-cache responder that terminates the pipeline's load/store request interface and returns exactly one in-order `data_ok` per accepted request to the memory stage. It sits between the EX-stage request port and a simple in-order SRAM/bus backend. It also publishes the number of requests it currently owns, so the memory stage can cross-check its own wait/cancel bookkeeping. It never drops a response: flushed requests are still answered, and the consumer discards them.

---
 rtl/dcache_rsp_unit_pkg.sv | 22 ++
 rtl/dcache_req_fifo.sv | 54 +++++
 rtl/dcache_rsp_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/dcache_rsp_unit_pkg.sv
// Shared widths and request-entry layout for the data-cache responder.
package dcache_rsp_unit_pkg;

  localparam int DCACHE_DATA_W        = 32;
  localparam int DCACHE_ADDR_W        = 32;
  localparam int DCACHE_DISPOSE_NUM_W = 2;

  typedef struct packed {
    logic                       we;
    logic [DCACHE_ADDR_W-1:0]   addr;
    logic [DCACHE_DATA_W/8-1:0] wstrb;
    logic [DCACHE_DATA_W-1:0]   wdata;
  } dcache_req_t;

  localparam int DCACHE_REQ_W = $bits(dcache_req_t);

  // Flattened entry width for non-default address/data widths.
  function automatic int req_bus_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w / 8 + data_w;
  endfunction

endpackage

// File: rtl/dcache_req_fifo.sv
// DEPTH-entry request FIFO; head is the oldest entry, pointers wrap modulo DEPTH.
module dcache_req_fifo
  import dcache_rsp_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = DCACHE_REQ_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W:0]   count;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty  = (count == '0);
  assign pop_ok = pop & ~empty;
  assign head   = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= push_data;
        wptr      <= ptr_inc(wptr);
      end
      if (pop_ok) rptr <= ptr_inc(rptr);
      case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dcache_rsp_unit.sv
// In-order data-cache responder: one data_ok per accepted request.
// Optional protocol checker enabled by defining DCACHE_RSP_ERRCHK_EN.
module dcache_rsp_unit
  import dcache_rsp_unit_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = DCACHE_ADDR_W,
  parameter int DATA_W = DCACHE_DATA_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_i,
  input  logic                            we_i,
  input  logic [ADDR_W-1:0]               addr_i,
  input  logic [DATA_W/8-1:0]             wstrb_i,
  input  logic [DATA_W-1:0]               wdata_i,
  output logic                            addr_ok_o,
  output logic                            data_ok_o,
  output logic [DATA_W-1:0]               rdata_o,
  output logic [DCACHE_DISPOSE_NUM_W-1:0] dispose_inst_num_o,
  output logic                            mem_req_o,
  output logic                            mem_we_o,
  output logic [ADDR_W-1:0]               mem_addr_o,
  output logic [DATA_W/8-1:0]             mem_wstrb_o,
  output logic [DATA_W-1:0]               mem_wdata_o,
  input  logic                            mem_gnt_i,
  input  logic                            mem_rvalid_i,
  input  logic [DATA_W-1:0]               mem_rdata_i,
  output logic                            error_o
);

  localparam int REQ_W = req_bus_w(ADDR_W, DATA_W);
  localparam logic [DCACHE_DISPOSE_NUM_W-1:0] CNT_FULL = DCACHE_DISPOSE_NUM_W'(DEPTH);

  logic [DCACHE_DISPOSE_NUM_W-1:0] cnt;
  logic                            accept;
  logic                            fifo_empty;
  logic [REQ_W-1:0]                fifo_head;
  logic                            vld_p1;
  logic [DATA_W-1:0]               rdata_p1;

  // cnt covers FIFO entries, granted requests and the pending response,
  // so gating accepts on it is what keeps the FIFO from overflowing.
  assign addr_ok_o          = (cnt != CNT_FULL);
  assign accept             = req_i & addr_ok_o;
  assign dispose_inst_num_o = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      case ({accept, vld_p1})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  dcache_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REQ_W)
  ) u_req_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data ({we_i, addr_i, wstrb_i, wdata_i}),
    .pop       (mem_gnt_i),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign mem_req_o = ~fifo_empty;
  assign {mem_we_o, mem_addr_o, mem_wstrb_o, mem_wdata_o} = fifo_head;

  // Stage p1: registered backend response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1 <= mem_rvalid_i;
      if (mem_rvalid_i) rdata_p1 <= mem_rdata_i;
    end
  end

  assign data_ok_o = vld_p1;
  assign rdata_o   = rdata_p1;

`ifdef DCACHE_RSP_ERRCHK_EN
  logic [1:0] inflight;
  logic       err;
  logic       grant;

  assign grant = mem_gnt_i & mem_req_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
      err      <= 1'b0;
    end else begin
      case ({grant, mem_rvalid_i})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= (inflight == '0) ? inflight : inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      if ((mem_rvalid_i && inflight == '0) || (mem_gnt_i && !mem_req_o)) err <= 1'b1;
    end
  end

  assign error_o = err;
`else
  assign error_o = 1'b0;
`endif

endmodule
